// File: rtl/regfile_ctx_if.sv
// Register-file bus: write/read ports, load scoreboard and dump stream.
// master drives requests; slave is the register file.
interface regfile_ctx_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned BANK_W = 1
);
    logic              LD_REG;
    logic [ADDR_W-1:0] DR;
    logic [DATA_W-1:0] D;
    logic [BANK_W-1:0] BANK_SEL;
    logic [ADDR_W-1:0] SR1;
    logic [ADDR_W-1:0] SR2;
    logic [DATA_W-1:0] SR1_out;
    logic [DATA_W-1:0] SR2_out;
    logic              MARK_BUSY;
    logic [ADDR_W-1:0] MARK_DR;
    logic              SR1_busy;
    logic              SR2_busy;
    logic              DUMP_START;
    logic [BANK_W-1:0] DUMP_BANK;
    logic              DUMP_VALID;
    logic              DUMP_READY;
    logic [ADDR_W-1:0] DUMP_ADDR;
    logic [DATA_W-1:0] DUMP_DATA;
    logic              DUMP_BUSY;
    logic              DUMP_DONE;

    modport master (
        output LD_REG, DR, D, BANK_SEL, SR1, SR2, MARK_BUSY, MARK_DR,
               DUMP_START, DUMP_BANK, DUMP_READY,
        input  SR1_out, SR2_out, SR1_busy, SR2_busy,
               DUMP_VALID, DUMP_ADDR, DUMP_DATA, DUMP_BUSY, DUMP_DONE
    );

    modport slave (
        input  LD_REG, DR, D, BANK_SEL, SR1, SR2, MARK_BUSY, MARK_DR,
               DUMP_START, DUMP_BANK, DUMP_READY,
        output SR1_out, SR2_out, SR1_busy, SR2_busy,
               DUMP_VALID, DUMP_ADDR, DUMP_DATA, DUMP_BUSY, DUMP_DONE
    );
endinterface

// File: rtl/regfile_ctx.sv
// Banked LC-3 register file: 2 read / 1 write ports, optional bypass,
// per-register load scoreboard and a serial bank dump engine.
module regfile_ctx #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NUM_REGS  = 8,
    parameter int unsigned ADDR_W    = $clog2(NUM_REGS),
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    parameter int unsigned BYPASS    = 1
) (
    input  logic          Clk,
    input  logic          Reset,
    regfile_ctx_if.slave  bus
);
    localparam int unsigned LAST = NUM_REGS - 1;

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    logic [DATA_W-1:0]   regs_q [NUM_BANKS][NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_BANKS][NUM_REGS];
    logic [NUM_REGS-1:0] busy_q [NUM_BANKS];
    logic [NUM_REGS-1:0] busy_d [NUM_BANKS];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [BANK_W-1:0] dbank_q, dbank_d;
    logic [ADDR_W-1:0] daddr_q, daddr_d;
    logic [DATA_W-1:0] ddata_q, ddata_d;
    logic              dvalid_q, dvalid_d;
    logic              dbusy_q, dbusy_d;
    logic              ddone_q, ddone_d;

    function automatic logic in_range(input logic [BANK_W-1:0] b, input logic [ADDR_W-1:0] a);
        return (32'(b) < NUM_BANKS) && (32'(a) < NUM_REGS);
    endfunction

    // Stored (pre-edge) value; anything out of range reads as zero.
    function automatic logic [DATA_W-1:0] stored(input logic [BANK_W-1:0] b, input logic [ADDR_W-1:0] a);
        if (in_range(b, a)) return regs_q[b][a];
        return '0;
    endfunction

    function automatic logic busy_bit(input logic [BANK_W-1:0] b, input logic [ADDR_W-1:0] a);
        if (in_range(b, a)) return busy_q[b][a];
        return 1'b0;
    endfunction

    logic wr_en, mark_en, byp1, byp2;

    assign wr_en   = bus.LD_REG && in_range(bus.BANK_SEL, bus.DR);
    assign mark_en = bus.MARK_BUSY && in_range(bus.BANK_SEL, bus.MARK_DR);
    assign byp1    = (BYPASS != 0) && wr_en && (bus.DR == bus.SR1);
    assign byp2    = (BYPASS != 0) && wr_en && (bus.DR == bus.SR2);

    assign bus.SR1_out  = byp1 ? bus.D : stored(bus.BANK_SEL, bus.SR1);
    assign bus.SR2_out  = byp2 ? bus.D : stored(bus.BANK_SEL, bus.SR2);
    assign bus.SR1_busy = byp1 ? 1'b0 : busy_bit(bus.BANK_SEL, bus.SR1);
    assign bus.SR2_busy = byp2 ? 1'b0 : busy_bit(bus.BANK_SEL, bus.SR2);

    // Mark is applied after the write so a reissued load keeps the register busy.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_en) begin
            regs_d[bus.BANK_SEL][bus.DR] = bus.D;
            busy_d[bus.BANK_SEL][bus.DR] = 1'b0;
        end
        if (mark_en) begin
            busy_d[bus.BANK_SEL][bus.MARK_DR] = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                busy_q[b] <= '0;
                for (int r = 0; r < int'(NUM_REGS); r++) begin
                    regs_q[b][r] <= '0;
                end
            end
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Dump engine: each beat is a snapshot of stored state when loaded.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dbank_d = dbank_q;
        daddr_d = daddr_q;
        ddata_d = ddata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.DUMP_START) begin
                    dbank_d = bus.DUMP_BANK;
                    idx_d   = '0;
                    daddr_d = '0;
                    ddata_d = stored(bus.DUMP_BANK, '0);
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.DUMP_READY) begin
                    if (idx_q == ADDR_W'(LAST)) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        daddr_d = idx_q + ADDR_W'(1);
                        ddata_d = stored(dbank_q, idx_q + ADDR_W'(1));
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        dvalid_d = (state_d == SEND);
        dbusy_d  = (state_d != IDLE);
        ddone_d  = (state_d == DONE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            dbank_q  <= '0;
            daddr_q  <= '0;
            ddata_q  <= '0;
            dvalid_q <= 1'b0;
            dbusy_q  <= 1'b0;
            ddone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dbank_q  <= dbank_d;
            daddr_q  <= daddr_d;
            ddata_q  <= ddata_d;
            dvalid_q <= dvalid_d;
            dbusy_q  <= dbusy_d;
            ddone_q  <= ddone_d;
        end
    end

    assign bus.DUMP_VALID = dvalid_q;
    assign bus.DUMP_BUSY  = dbusy_q;
    assign bus.DUMP_DONE  = ddone_q;
    assign bus.DUMP_ADDR  = daddr_q;
    assign bus.DUMP_DATA  = ddata_q;
endmodule

// File: tb/tb_regfile_ctx.sv
// Directed bench for regfile_ctx: default build, a no-bypass build and a
// six-register build, all sharing clock and reset.
module tb_regfile_ctx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   beats;
    int   done_seen;

    always #5 clk = ~clk;

    regfile_ctx_if #(.DATA_W(16), .ADDR_W(3), .BANK_W(1)) b0 ();
    regfile_ctx_if #(.DATA_W(16), .ADDR_W(3), .BANK_W(1)) bn ();
    regfile_ctx_if #(.DATA_W(16), .ADDR_W(3), .BANK_W(1)) b6 ();

    regfile_ctx #(.BYPASS(1))   u0 (.Clk(clk), .Reset(rst), .bus(b0));
    regfile_ctx #(.BYPASS(0))   un (.Clk(clk), .Reset(rst), .bus(bn));
    regfile_ctx #(.NUM_REGS(6)) u6 (.Clk(clk), .Reset(rst), .bus(b6));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        {b0.LD_REG, b0.DR, b0.D, b0.BANK_SEL, b0.SR1, b0.SR2, b0.MARK_BUSY, b0.MARK_DR,
         b0.DUMP_START, b0.DUMP_BANK, b0.DUMP_READY} = '0;
        {bn.LD_REG, bn.DR, bn.D, bn.BANK_SEL, bn.SR1, bn.SR2, bn.MARK_BUSY, bn.MARK_DR,
         bn.DUMP_START, bn.DUMP_BANK, bn.DUMP_READY} = '0;
        {b6.LD_REG, b6.DR, b6.D, b6.BANK_SEL, b6.SR1, b6.SR2, b6.MARK_BUSY, b6.MARK_DR,
         b6.DUMP_START, b6.DUMP_BANK, b6.DUMP_READY} = '0;
        tick();
        tick();
        chk("rst_sr1", 32'(b0.SR1_out), 32'h0);
        chk("rst_valid", 32'(b0.DUMP_VALID), 32'h0);
        chk("rst_busy", 32'(b0.DUMP_BUSY), 32'h0);
        chk("rst_done", 32'(b0.DUMP_DONE), 32'h0);
        chk("rst_daddr", 32'(b0.DUMP_ADDR), 32'h0);
        chk("rst_ddata", 32'(b0.DUMP_DATA), 32'h0);
        rst = 1'b0;

        // Banked writes
        b0.LD_REG = 1'b1; b0.DR = 3'd3; b0.D = 16'h1234; b0.BANK_SEL = 1'b0;
        tick();
        b0.D = 16'hBEEF; b0.BANK_SEL = 1'b1;
        tick();
        b0.LD_REG = 1'b0;
        b0.BANK_SEL = 1'b0; b0.SR1 = 3'd3; b0.SR2 = 3'd0;
        #1;
        chk("b0_r3", 32'(b0.SR1_out), 32'h1234);
        chk("b0_r0", 32'(b0.SR2_out), 32'h0);
        b0.BANK_SEL = 1'b1;
        #1;
        chk("b1_r3", 32'(b0.SR1_out), 32'hBEEF);
        chk("b1_r0", 32'(b0.SR2_out), 32'h0);

        // Bypass vs. no bypass
        b0.BANK_SEL = 1'b0; b0.LD_REG = 1'b1; b0.DR = 3'd5; b0.D = 16'hA5A5;
        b0.SR1 = 3'd5; b0.SR2 = 3'd5;
        bn.LD_REG = 1'b1; bn.DR = 3'd5; bn.D = 16'hA5A5; bn.SR1 = 3'd5; bn.SR2 = 3'd5;
        #1;
        chk("byp_sr1", 32'(b0.SR1_out), 32'hA5A5);
        chk("byp_sr2", 32'(b0.SR2_out), 32'hA5A5);
        chk("nobyp_sr1", 32'(bn.SR1_out), 32'h0);
        chk("nobyp_sr2", 32'(bn.SR2_out), 32'h0);
        tick();
        b0.LD_REG = 1'b0; bn.LD_REG = 1'b0;
        #1;
        chk("byp_after", 32'(b0.SR1_out), 32'hA5A5);
        chk("nobyp_after", 32'(bn.SR2_out), 32'hA5A5);

        // Scoreboard
        b0.MARK_BUSY = 1'b1; b0.MARK_DR = 3'd2;
        tick();
        b0.MARK_BUSY = 1'b0; b0.SR1 = 3'd2; b0.SR2 = 3'd2;
        #1;
        chk("mark_busy1", 32'(b0.SR1_busy), 32'h1);
        chk("mark_busy2", 32'(b0.SR2_busy), 32'h1);
        b0.LD_REG = 1'b1; b0.DR = 3'd2; b0.D = 16'h2222;
        #1;
        chk("byp_busy", 32'(b0.SR1_busy), 32'h0);
        chk("byp_data", 32'(b0.SR1_out), 32'h2222);
        tick();
        b0.LD_REG = 1'b0;
        #1;
        chk("wr_clr_busy", 32'(b0.SR1_busy), 32'h0);
        b0.LD_REG = 1'b1; b0.D = 16'h3333; b0.MARK_BUSY = 1'b1; b0.MARK_DR = 3'd2;
        tick();
        b0.LD_REG = 1'b0; b0.MARK_BUSY = 1'b0;
        #1;
        chk("set_wins_busy", 32'(b0.SR1_busy), 32'h1);
        chk("set_wins_data", 32'(b0.SR1_out), 32'h3333);
        b0.BANK_SEL = 1'b1;
        #1;
        chk("busy_other_bank", 32'(b0.SR1_busy), 32'h0);

        // Fill bank 1 with 0x10..0x17
        for (int i = 0; i < 8; i++) begin
            b0.LD_REG = 1'b1; b0.BANK_SEL = 1'b1; b0.DR = 3'(i); b0.D = 16'(16 + i);
            tick();
        end
        b0.LD_REG = 1'b0; b0.BANK_SEL = 1'b0;

        // Full-rate dump of bank 1
        b0.DUMP_READY = 1'b1; b0.DUMP_BANK = 1'b1; b0.DUMP_START = 1'b1;
        tick();
        b0.DUMP_START = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("dump_valid", 32'(b0.DUMP_VALID), 32'h1);
            chk("dump_addr", 32'(b0.DUMP_ADDR), 32'(i));
            chk("dump_data", 32'(b0.DUMP_DATA), 32'(16 + i));
            tick();
        end
        chk("done_pulse", 32'(b0.DUMP_DONE), 32'h1);
        chk("done_valid", 32'(b0.DUMP_VALID), 32'h0);
        chk("done_busy", 32'(b0.DUMP_BUSY), 32'h1);
        b0.DUMP_START = 1'b1;
        tick();
        b0.DUMP_START = 1'b0;
        chk("idle_after_done", 32'(b0.DUMP_BUSY), 32'h0);
        chk("done_cleared", 32'(b0.DUMP_DONE), 32'h0);
        chk("start_in_done_ignored", 32'(b0.DUMP_VALID), 32'h0);

        // Stalled dump with a write under beat 4
        b0.DUMP_READY = 1'b0; b0.DUMP_START = 1'b1;
        tick();
        b0.DUMP_START = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("stall_addr", 32'(b0.DUMP_ADDR), 32'(i));
            chk("stall_data", 32'(b0.DUMP_DATA), 32'(16 + i));
            if (i == 2) begin
                b0.DUMP_START = 1'b1; b0.DUMP_BANK = 1'b0;
                tick();
                b0.DUMP_START = 1'b0;
                chk("restart_ignored", 32'(b0.DUMP_DATA), 32'h12);
            end
            if (i == 4) begin
                b0.LD_REG = 1'b1; b0.BANK_SEL = 1'b1; b0.DR = 3'd4; b0.D = 16'hDEAD;
                tick();
                b0.LD_REG = 1'b0;
                chk("snapshot_held", 32'(b0.DUMP_DATA), 32'h14);
            end
            b0.DUMP_READY = 1'b1;
            tick();
            b0.DUMP_READY = 1'b0;
        end
        chk("stall_done", 32'(b0.DUMP_DONE), 32'h1);
        tick();
        chk("stall_idle", 32'(b0.DUMP_BUSY), 32'h0);
        b0.BANK_SEL = 1'b1; b0.SR1 = 3'd4;
        #1;
        chk("new_r4", 32'(b0.SR1_out), 32'hDEAD);

        // Reset in the middle of a dump
        b0.DUMP_READY = 1'b1; b0.DUMP_BANK = 1'b1; b0.DUMP_START = 1'b1;
        tick();
        b0.DUMP_START = 1'b0;
        tick(); tick(); tick();
        chk("beat3_addr", 32'(b0.DUMP_ADDR), 32'h3);
        rst = 1'b1;
        #1;
        chk("abort_valid", 32'(b0.DUMP_VALID), 32'h0);
        chk("abort_busy", 32'(b0.DUMP_BUSY), 32'h0);
        chk("abort_done", 32'(b0.DUMP_DONE), 32'h0);
        b0.SR1 = 3'd3;
        #1;
        chk("abort_b1_r3", 32'(b0.SR1_out), 32'h0);
        b0.BANK_SEL = 1'b0;
        #1;
        chk("abort_b0_r3", 32'(b0.SR1_out), 32'h0);
        tick();
        rst = 1'b0;
        b0.DUMP_START = 1'b1;
        tick();
        b0.DUMP_START = 1'b0;
        chk("restart_valid", 32'(b0.DUMP_VALID), 32'h1);
        chk("restart_addr", 32'(b0.DUMP_ADDR), 32'h0);
        chk("restart_data", 32'(b0.DUMP_DATA), 32'h0);
        repeat (9) tick();
        chk("restart_idle", 32'(b0.DUMP_BUSY), 32'h0);

        // Six-register build
        b6.LD_REG = 1'b1; b6.DR = 3'd5; b6.D = 16'h0055;
        tick();
        b6.DR = 3'd6; b6.D = 16'h0066;
        tick();
        b6.LD_REG = 1'b0; b6.SR1 = 3'd7; b6.SR2 = 3'd5;
        #1;
        chk("n6_sr7", 32'(b6.SR1_out), 32'h0);
        chk("n6_sr5", 32'(b6.SR2_out), 32'h55);
        b6.SR1 = 3'd6;
        #1;
        chk("n6_dr6_ignored", 32'(b6.SR1_out), 32'h0);
        b6.DUMP_READY = 1'b1; b6.DUMP_START = 1'b1;
        tick();
        b6.DUMP_START = 1'b0;
        beats = 0;
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (b6.DUMP_VALID) beats++;
            if (b6.DUMP_DONE) done_seen++;
            tick();
        end
        chk("n6_beats", 32'(beats), 32'd6);
        chk("n6_done", 32'(done_seen), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_ctx.md
Name: regfile_ctx

Overview:
- Parametrised general-purpose register file for the LC-3 datapath, sized by data width, register count and context-bank count.
- Two combinational read ports and one write port, with optional write-to-read bypass.
- Per-register busy scoreboard for pending loads.
- Serial dump engine streams a whole bank over a valid/ready handshake for context save and debug.
- Sits between the bus/ALU and the control FSM, in place of the fixed 8x16 file.

Parameters:
- DATA_W, 16: register width in bits.
- NUM_REGS, 8: registers per bank, >=2; need not be a power of two.
- ADDR_W, $clog2(NUM_REGS): register address width.
- NUM_BANKS, 2: context banks (0 = user, 1 = supervisor), >=1.
- BANK_W, max(1,$clog2(NUM_BANKS)): bank select width.
- BYPASS, 1: 1 = same-cycle write data is forwarded to the read ports; 0 = reads show stored value only.

Ports:
- Clk in 1: clock; all state updates on the rising edge.
- Reset in 1: asynchronous, active-high; clears all state.
- LD_REG in 1: write enable.
- DR in ADDR_W: write address.
- D in DATA_W: write data.
- BANK_SEL in BANK_W: active bank for reads, writes and scoreboard.
- SR1 in ADDR_W: read port 1 address.
- SR2 in ADDR_W: read port 2 address.
- SR1_out out DATA_W: read port 1 data.
- SR2_out out DATA_W: read port 2 data.
- MARK_BUSY in 1: set the busy bit of MARK_DR (pending load issued).
- MARK_DR in ADDR_W: register to mark busy.
- SR1_busy out 1: busy flag of SR1 in the active bank.
- SR2_busy out 1: busy flag of SR2 in the active bank.
- DUMP_START in 1: request a dump; sampled only in IDLE.
- DUMP_BANK in BANK_W: bank to dump; latched on start.
- DUMP_VALID out 1: dump beat valid.
- DUMP_READY in 1: consumer accepts the beat.
- DUMP_ADDR out ADDR_W: register index of the current beat.
- DUMP_DATA out DATA_W: register value of the current beat.
- DUMP_BUSY out 1: dump engine not in IDLE.
- DUMP_DONE out 1: one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (asynchronous, active-high): all registers in all banks = 0; all busy bits = 0; dump FSM = IDLE; DUMP_VALID, DUMP_BUSY, DUMP_DONE, DUMP_ADDR, DUMP_DATA = 0.
  - Reset asserted mid-dump aborts the dump immediately; no DONE pulse is produced.
- Write: on a rising edge with LD_REG=1 and DR<NUM_REGS, reg[BANK_SEL][DR] <= D, and busy[BANK_SEL][DR] is cleared.
  - DR>=NUM_REGS: write ignored.
- Read: SRx_out = reg[BANK_SEL][SRx], combinational, zero latency. SRx>=NUM_REGS returns 0.
  - BYPASS=1 with LD_REG=1, DR==SRx and DR<NUM_REGS: SRx_out = D and SRx_busy = 0 in the same cycle.
  - SR1 and SR2 may be equal; both ports return the same value.
- Scoreboard: MARK_BUSY=1 sets busy[BANK_SEL][MARK_DR] at the edge.
  - MARK_BUSY and LD_REG to the same register in the same cycle: set wins, so the register ends busy (a new load is issued behind the completing one).
  - MARK_DR>=NUM_REGS: ignored.
  - SRx_busy = busy[BANK_SEL][SRx]; returns 0 for out-of-range SRx.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: DUMP_START=1 latches DUMP_BANK into dbank, sets idx=0, loads DUMP_DATA <= reg[dbank][0] (stored value, not bypassed) and DUMP_ADDR <= 0; next state SEND.
  - SEND: DUMP_VALID=1. DUMP_ADDR and DUMP_DATA are held stable while DUMP_READY=0.
    - Handshake with idx<NUM_REGS-1: idx+1; DUMP_DATA <= stored reg[dbank][idx+1].
    - Handshake with idx=NUM_REGS-1: next state DONE.
  - DONE: DUMP_DONE=1 for exactly one cycle, DUMP_VALID=0; next state IDLE.
  - DUMP_BUSY=1 in SEND and DONE.
  - DUMP_START outside IDLE is ignored, including in the DONE cycle.
  - Minimum dump length is NUM_REGS+1 cycles after start with DUMP_READY held at 1.
- Normal reads and writes continue during a dump.
  - Each beat is a snapshot taken when the beat is loaded. A later write to that register does not change the held DUMP_DATA.
  - A write landing on the same edge a beat is loaded is not reflected in that beat.
- All index arithmetic is unsigned ADDR_W-bit. idx never exceeds NUM_REGS-1 and never wraps.

Test Plan:
- Reset, then write R3=16'h1234 (bank 0) and R3=16'hBEEF (bank 1) -> bank 0 reads 16'h1234, bank 1 reads 16'hBEEF, R0 reads 16'h0000 in both banks.
- BYPASS=1: LD_REG=1, DR=5, D=16'hA5A5 with SR1=SR2=5 in the same cycle -> both ports read 16'hA5A5 combinationally. BYPASS=0 -> both read the old value until the next cycle.
- MARK_BUSY on R2 -> SR1_busy=1 when SR1=2. Write R2 -> busy cleared at the edge. Simultaneous MARK_BUSY and write to R2 -> busy remains 1 and data is updated.
- Dump bank 1 (values 16'h0010..16'h0017) with DUMP_READY=1 -> 8 beats, ADDR 0..7 in order, then DONE pulse; total 9 cycles after start.
- Dump with DUMP_READY toggling, and a write to R4 while beat 4 is stalled -> beat 4 keeps the old R4 value; later reads return the new value. DUMP_START during the dump is ignored.
- Assert Reset at beat 3 of a dump -> DUMP_VALID, DUMP_BUSY and DUMP_DONE drop to 0 immediately, all registers read 0, and a new DUMP_START is accepted after release.
- NUM_REGS=6 build: SR1=7 reads 0, a write to DR=6 is ignored, and a dump emits exactly 6 beats.
